// File: rtl/rec_event_collector.sv
// Multi-channel event collector: a toggle on a channel's event bit captures its payload,
// captures are granted round-robin into a shared FIFO drained over valid/ready.
module rec_event_collector #(
    parameter int                 NUM_CH        = 2,
    parameter int                 DATA_W        = 4,
    parameter int                 DEPTH         = 8,
    parameter logic [DATA_W-1:0]  MATCH_PATTERN = DATA_W'(9),
    localparam int                CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int                CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_evt,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_match,
    output logic [CNT_W-1:0]         fifo_count,
    output logic                     overflow,
    output logic [15:0]              match_count
);
    localparam int               AW      = CNT_W - 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Handshake: an entry transfers on any rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready.

    logic                prime_q;
    logic [NUM_CH-1:0]   evt_q;
    logic [NUM_CH-1:0]   evt;
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [DATA_W-1:0]   hold_q [NUM_CH];
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [CH_W-1:0]     gnt_ch;
    logic                gnt_found;
    logic                grant;
    logic                pop;
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    wr_q, rd_q;
    logic [15:0]         mc_q;
    logic [DATA_W-1:0]   mem_data  [DEPTH];
    logic [CH_W-1:0]     mem_ch    [DEPTH];
    logic                mem_match [DEPTH];

    // The first edge after reset only primes evt_q so held-high inputs are not events.
    assign evt        = prime_q ? '0 : (ch_evt ^ evt_q);
    assign fifo_count = wr_q - rd_q;
    assign out_valid  = (wr_q != rd_q);
    assign pop        = out_valid && out_ready;

    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        // Two passes give the rotated priority: channels at/after rr_q first, then the wrap.
        for (int j = 0; j < NUM_CH; j++) begin
            if (!gnt_found && (j >= int'(rr_q)) && pend_q[j]) begin
                gnt_found = 1'b1;
                gnt_ch    = CH_W'(j);
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!gnt_found && (j < int'(rr_q)) && pend_q[j]) begin
                gnt_found = 1'b1;
                gnt_ch    = CH_W'(j);
            end
        end
        grant = gnt_found && ((fifo_count != DEPTH_C) || pop);
        rr_d  = rr_q;
        if (grant) begin
            rr_d = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
        end
    end

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (grant) begin
            pend_d[gnt_ch] = 1'b0;
        end
        // A re-event only loses data if the old capture was not granted this same edge.
        for (int i = 0; i < NUM_CH; i++) begin
            if (evt[i]) begin
                if (pend_d[i]) begin
                    ovf_d = 1'b1;
                end
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_q <= 1'b1;
            evt_q   <= '0;
            pend_q  <= '0;
            rr_q    <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            mc_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            prime_q <= 1'b0;
            evt_q   <= ch_evt;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (evt[i]) begin
                    hold_q[i] <= ch_data[i*DATA_W +: DATA_W];
                end
            end
            if (grant) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (pop && out_match && (mc_q != 16'hFFFF)) begin
                mc_q <= mc_q + 16'd1;
            end
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (grant) begin
            mem_data[wr_q[AW-1:0]]  <= hold_q[gnt_ch];
            mem_ch[wr_q[AW-1:0]]    <= gnt_ch;
            mem_match[wr_q[AW-1:0]] <= (hold_q[gnt_ch] == MATCH_PATTERN);
        end
    end

    assign out_data    = out_valid ? mem_data[rd_q[AW-1:0]] : '0;
    assign out_ch      = out_valid ? mem_ch[rd_q[AW-1:0]] : '0;
    assign out_match   = out_valid ? mem_match[rd_q[AW-1:0]] : 1'b0;
    assign overflow    = ovf_q;
    assign match_count = mc_q;

endmodule

// File: tb/tb_rec_event_collector.sv
// Bench for rec_event_collector: directed vector table, hand sequences for full/overflow
// and asynchronous reset, then random traffic checked against a queue-based model.
module tb_rec_event_collector;
    localparam int         NUM_CH = 2;
    localparam int         DATA_W = 4;
    localparam int         DEPTH  = 8;
    localparam logic [3:0] MATCH  = 4'h9;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  ch_evt = 2'b00;
    logic [7:0]  ch_data = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_data;
    logic [0:0]  out_ch;
    logic        out_match;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic [15:0] match_count;

    int n_checks = 0;
    int n_fail   = 0;

    rec_event_collector #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .MATCH_PATTERN(MATCH)
    ) dut (
        .clk(clk), .reset(reset), .ch_evt(ch_evt), .ch_data(ch_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_match(out_match), .fifo_count(fifo_count),
        .overflow(overflow), .match_count(match_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- reference model / scoreboard ----------------
    logic [4:0] exp_q[$];          // {channel, payload} in FIFO order
    bit         m_prime;
    bit [1:0]   m_evtq;
    bit         m_pend [NUM_CH];
    int         m_hold [NUM_CH];
    int         m_rr;
    bit         m_ovf;
    int         m_mc;

    function automatic void model_reset();
        exp_q.delete();
        m_prime = 1'b1;
        m_evtq  = '0;
        m_rr    = 0;
        m_ovf   = 1'b0;
        m_mc    = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_pend[c] = 1'b0;
            m_hold[c] = 0;
        end
    endfunction

    function automatic void model_edge();
        bit         do_pop;
        int         g;
        logic [4:0] head;
        do_pop = (exp_q.size() > 0) && out_ready;
        g = -1;
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (m_rr + k) % NUM_CH;
            if (g < 0 && m_pend[c]) g = c;
        end
        if (g >= 0 && !((exp_q.size() < DEPTH) || do_pop)) g = -1;
        if (do_pop) begin
            head = exp_q.pop_front();
            if (head[3:0] == MATCH && m_mc < 65535) m_mc++;
        end
        if (g >= 0) begin
            exp_q.push_back({1'(g), 4'(m_hold[g])});
            m_pend[g] = 1'b0;
            m_rr = (g + 1) % NUM_CH;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!m_prime && ch_evt[c] != m_evtq[c]) begin
                if (m_pend[c]) m_ovf = 1'b1;
                m_pend[c] = 1'b1;
                m_hold[c] = int'(ch_data[c*4 +: 4]);
            end
        end
        m_evtq  = ch_evt;
        m_prime = 1'b0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("mdl_valid", int'(out_valid), int'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check("mdl_data", int'(out_data), int'(exp_q[0][3:0]));
            check("mdl_ch", int'(out_ch), int'(exp_q[0][4]));
            check("mdl_match", int'(out_match), int'(exp_q[0][3:0] == MATCH));
        end
        check("mdl_count", int'(fifo_count), exp_q.size());
        check("mdl_overflow", int'(overflow), int'(m_ovf));
        check("mdl_match_count", int'(match_count), m_mc);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset(input logic [1:0] evt);
        ch_evt = evt;
        reset  = 1'b1;
        #1;
        model_reset();
        check("rst_valid", int'(out_valid), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_match_count", int'(match_count), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_ch", int'(out_ch), 0);
        check("rst_match", int'(out_match), 0);
        cyc();
        cyc();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  evt;
        logic [3:0]  d0;
        logic [3:0]  d1;
        logic        rdy;
        logic        v;
        logic [3:0]  d;
        logic        c;
        logic        m;
        logic [3:0]  cnt;
        logic [15:0] mc;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [3:0] drain_exp [9];

        tbl[0]  = '{2'b11, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 16'd0};
        tbl[1]  = '{2'b10, 4'h9, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 16'd0};
        tbl[2]  = '{2'b10, 4'h0, 4'h0, 1'b1, 1'b1, 4'h9, 1'b0, 1'b1, 4'd1, 16'd0};
        tbl[3]  = '{2'b10, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 16'd1};
        tbl[4]  = '{2'b00, 4'h0, 4'hA, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 16'd1};
        tbl[5]  = '{2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 4'd1, 16'd1};
        tbl[6]  = '{2'b11, 4'h3, 4'h5, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 16'd1};
        tbl[7]  = '{2'b11, 4'h0, 4'h0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 4'd1, 16'd1};
        tbl[8]  = '{2'b11, 4'h0, 4'h0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 4'd2, 16'd1};
        tbl[9]  = '{2'b11, 4'h0, 4'h0, 1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 4'd1, 16'd1};
        tbl[10] = '{2'b11, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 16'd1};
        tbl[11] = '{2'b10, 4'h2, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 16'd1};
        tbl[12] = '{2'b10, 4'h0, 4'h0, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 4'd1, 16'd1};
        tbl[13] = '{2'b01, 4'h6, 4'h7, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 16'd1};
        tbl[14] = '{2'b01, 4'h0, 4'h0, 1'b0, 1'b1, 4'h7, 1'b1, 1'b0, 4'd1, 16'd1};
        tbl[15] = '{2'b01, 4'h0, 4'h0, 1'b0, 1'b1, 4'h7, 1'b1, 1'b0, 4'd2, 16'd1};
        tbl[16] = '{2'b01, 4'h0, 4'h0, 1'b1, 1'b1, 4'h6, 1'b0, 1'b0, 4'd1, 16'd1};
        tbl[17] = '{2'b01, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 16'd1};

        // Held-high events through reset must not create entries.
        do_reset(2'b11);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("prime_valid", int'(out_valid), 0);
            check("prime_count", int'(fifo_count), 0);
            check("prime_overflow", int'(overflow), 0);
        end

        for (int i = 0; i < 18; i++) begin
            ch_evt    = tbl[i].evt;
            ch_data   = {tbl[i].d1, tbl[i].d0};
            out_ready = tbl[i].rdy;
            cyc();
            check($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].v));
            if (tbl[i].v) begin
                check($sformatf("tbl%0d_data", i), int'(out_data), int'(tbl[i].d));
                check($sformatf("tbl%0d_ch", i), int'(out_ch), int'(tbl[i].c));
                check($sformatf("tbl%0d_match", i), int'(out_match), int'(tbl[i].m));
            end
            check($sformatf("tbl%0d_count", i), int'(fifo_count), int'(tbl[i].cnt));
            check($sformatf("tbl%0d_match_count", i), int'(match_count), int'(tbl[i].mc));
        end

        // Fill the FIFO with ch0 events 1..8, leave event 9 pending, overwrite it with 10.
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            ch_evt[0]    = ~ch_evt[0];
            ch_data[3:0] = 4'(k);
            cyc();
            cyc();
            cyc();
        end
        check("full_count", int'(fifo_count), 8);
        check("full_overflow", int'(overflow), 0);
        ch_evt[0]    = ~ch_evt[0];
        ch_data[3:0] = 4'hA;
        cyc();
        check("lost_overflow", int'(overflow), 1);
        check("lost_count", int'(fifo_count), 8);

        for (int k = 0; k < 8; k++) drain_exp[k] = 4'(k + 1);
        drain_exp[8] = 4'hA;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("drain%0d_valid", k), int'(out_valid), 1);
            check($sformatf("drain%0d_data", k), int'(out_data), int'(drain_exp[k]));
            cyc();
            if (k == 0) check("push_pop_count", int'(fifo_count), 8);
        end
        check("drained_valid", int'(out_valid), 0);
        check("drained_count", int'(fifo_count), 0);

        // Accumulate five entries, then reset between clock edges.
        out_ready = 1'b0;
        for (int k = 0; k < 30 && exp_q.size() < 5; k++) begin
            ch_evt  = ~ch_evt;
            ch_data = 8'($urandom);
            cyc();
        end
        check("pre_reset_count", int'(fifo_count), 5);
        #2;
        do_reset(ch_evt);
        for (int i = 0; i < 4; i++) cyc();
        check("post_reset_count", int'(fifo_count), 0);

        // Random traffic: a busy-consumer phase, then a sluggish one that reaches full.
        for (int i = 0; i < 600; i++) begin
            ch_evt    = ch_evt ^ 2'($urandom_range(0, 3) & $urandom_range(0, 3));
            ch_data   = 8'($urandom);
            out_ready = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
